odd_even_sorter: RTL and testbench
==================================

Name: odd_even_sorter

Overview:
Parametrised successor to the 2-input compare-swap sorter stage. It loads N words serially, sorts them in place by odd-even transposition (one phase per clock), then streams them out in sorted order. Sort direction is selectable, and the sort exits early once the data is sorted. Valid/ready handshakes on both sides let it sit between streaming producer and consumer stages in the sorter datapath.

Parameters:
WIDTH, 4, bit width of each data word (unsigned compare)
N, 8, number of words per sort batch; must be even and >= 2
CW, $clog2(N+1), width of internal slot and phase counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  input word
mode_desc  input  1  0 = ascending, 1 = descending; sampled with the first accepted word of a batch
out_valid  output  1  out_data holds a sorted word
out_ready  input  1  consumer accepts out_data
out_data  output  WIDTH  sorted output word
out_last  output  1  high with the final (Nth) output word
busy  output  1  high in LOAD, SORT or DRAIN

Behaviour:
- States: IDLE, LOAD, SORT, DRAIN. All registers are cleared by reset.
- Reset values: state=IDLE, storage array=0, counters=0, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, latched mode=0.
- in_ready = 1 in IDLE and LOAD only. Accept condition: in_valid && in_ready.
- IDLE: the first accept writes slot 0, latches mode_desc, and moves to LOAD with wr_ptr=1.
- LOAD: each accept writes slot wr_ptr and increments wr_ptr. The accept of slot N-1 moves to SORT on the next cycle with phase=0. Gaps (in_valid low) are allowed with no effect.
- SORT: one phase per cycle.
  - Even phase (phase[0]=0) compare-swaps pairs (0,1),(2,3),...
  - Odd phase compare-swaps pairs (1,2),(3,4),... Slot 0 and slot N-1 are untouched in odd phases.
  - Swap rule: ascending swaps if lo>hi; descending swaps if lo<hi; equal words are never swapped (stable).
  - Each phase records whether any swap occurred.
  - Exit SORT when N phases have completed, or when the current phase and the previous phase both had zero swaps, whichever comes first. The very first phase alone never triggers early exit.
  - On exit, rd_ptr=0 and state=DRAIN on the next cycle.
- DRAIN:
  - out_valid=1; out_data = slot[rd_ptr]; out_last = (rd_ptr==N-1).
  - On out_valid && out_ready, rd_ptr increments.
  - The handshake on the last word moves to IDLE next cycle, with out_valid=0 and out_last=0.
  - out_data and out_last are held stable while out_valid && !out_ready.
- in_ready=0 throughout SORT and DRAIN; in_valid is ignored there.
- out_valid=0 outside DRAIN.
- busy = (state != IDLE).
- Reset asserted mid-operation (any state) aborts the batch immediately. Outputs return to their reset values asynchronously; no partial output follows.
- Compares are unsigned on the full WIDTH. No arithmetic overflow is possible.
- Latency from the Nth input accept to the first out_valid = (phases executed) + 1 cycles, where phases executed is between 2 and N.

Test Plan:
1. N=4, WIDTH=4, ascending; load 3,2,1,0 -> all 4 phases swap; out_valid rises 5 cycles after the last accept; outputs 0,1,2,3 with out_last on 3.
2. N=4, ascending; load 0,1,2,3 -> early exit after 2 phases; out_valid rises 3 cycles after the last accept; outputs 0,1,2,3.
3. N=4, mode_desc=1 on the first word (then driven 0); load 1,3,0,2 -> outputs 3,2,1,0; mode change mid-load is ignored.
4. N=4, ascending; load 2,1,2,1 with in_valid gaps; hold out_ready=0 for 3 cycles on word 2 -> outputs 1,1,2,2; out_data is stable while stalled; no word is dropped or duplicated.
5. N=8, WIDTH=4; load 15,0,7,7,8,1,14,2 -> outputs 0,1,2,7,7,8,14,15; busy=1 from the first accept through the last output handshake.
6. Assert rst_n=0 during SORT phase 1 -> busy, out_valid and in_ready drop immediately; after release, a new batch 3,2,1,0 sorts correctly to 0,1,2,3.

Source files
------------

// File: rtl/odd_even_sorter.sv
// Serial-load, in-place odd-even transposition sorter with early exit and
// valid/ready streaming on both the load and drain sides.
//
// state | meaning
// IDLE  | waiting for the first word of a batch
// LOAD  | filling slots 1..N-1
// SORT  | one compare-swap phase per clock until sorted or N phases done
// DRAIN | streaming slot[rd_ptr] out under out_ready back-pressure
module odd_even_sorter #(
  parameter int WIDTH = 4,
  parameter int N     = 8,
  parameter int CW    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode_desc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem     [N];
  logic [WIDTH-1:0] mem_nxt [N];
  logic [CW-1:0]    wr_ptr, rd_ptr, phase;
  logic             mode_q, swap_cur, swap_prev, init_done;
  logic             accept, out_fire, phase_swap, sort_done;

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // Two back-to-back quiet phases (one even, one odd) prove the array is sorted.
  assign sort_done = (phase == CW'(N)) ||
                     ((phase >= CW'(2)) && !swap_cur && !swap_prev);

  always_comb begin
    phase_swap = 1'b0;
    for (int i = 0; i < N; i++) mem_nxt[i] = mem[i];
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2) == int'(phase[0])) begin
        if (mode_q ? (mem[i] < mem[i+1]) : (mem[i] > mem[i+1])) begin
          mem_nxt[i]   = mem[i+1];
          mem_nxt[i+1] = mem[i];
          phase_swap   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = LOAD;
      LOAD:  if (accept && (wr_ptr == CW'(N-1))) state_nxt = SORT;
      SORT:  if (sort_done) state_nxt = DRAIN;
      DRAIN: if (out_fire && (rd_ptr == CW'(N-1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = init_done && ((state == IDLE) || (state == LOAD));
    out_valid = (state == DRAIN);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    out_last  = out_valid && (rd_ptr == CW'(N-1));
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      phase     <= '0;
      mode_q    <= 1'b0;
      swap_cur  <= 1'b0;
      swap_prev <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            mem[0] <= in_data;
            mode_q <= mode_desc;
            wr_ptr <= CW'(1);
          end
        end
        LOAD: begin
          if (accept) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + CW'(1);
            if (wr_ptr == CW'(N-1)) begin
              wr_ptr    <= '0;
              phase     <= '0;
              swap_cur  <= 1'b0;
              swap_prev <= 1'b0;
            end
          end
        end
        SORT: begin
          if (sort_done) begin
            rd_ptr <= '0;
          end else begin
            for (int i = 0; i < N; i++) mem[i] <= mem_nxt[i];
            phase     <= phase + CW'(1);
            swap_prev <= swap_cur;
            swap_cur  <= phase_swap;
          end
        end
        DRAIN: begin
          if (out_fire) rd_ptr <= (rd_ptr == CW'(N-1)) ? '0 : rd_ptr + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_odd_even_sorter.sv
// Bench for odd_even_sorter: an N=4 and an N=8 instance, directed cases plus
// random batches checked against a queue-based odd-even transposition model.
module tb_odd_even_sorter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid [2];
  logic       in_ready [2];
  logic [3:0] in_data  [2];
  logic       mode_desc[2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic [3:0] out_data [2];
  logic       out_last [2];
  logic       busy     [2];

  int n_checks = 0;
  int n_errors = 0;
  int stim[$];
  int exp_q[$];
  int exp_phases;

  always #5 clk = ~clk;

  odd_even_sorter #(.WIDTH(4), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .mode_desc(mode_desc[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]));

  odd_even_sorter #(.WIDTH(4), .N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .mode_desc(mode_desc[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]));

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain odd-even transposition on a queue, then a library sort for the result.
  task automatic model(input bit desc);
    int a[$];
    bit sw[$];
    int p;
    int t;
    bit any;
    a = stim;
    sw = {};
    p = 0;
    while (p < a.size()) begin
      any = 0;
      for (int i = p % 2; i + 1 < a.size(); i += 2) begin
        if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t; any = 1;
        end
      end
      sw.push_back(any);
      p++;
      if (p >= 2 && !sw[p-1] && !sw[p-2]) break;
    end
    exp_phases = p;
    exp_q = stim;
    if (desc) exp_q.rsort(); else exp_q.sort();
  endtask

  task automatic run_batch(input int d, input bit desc, input int gap_pct,
                           input int stall_pct, input int stall_word);
    int n;
    int guard;
    int lat;
    int stalls;
    logic [3:0] held;
    n = stim.size();
    model(desc);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < gap_pct) begin
        repeat ($urandom_range(3, 1)) begin
          in_valid[d] = 1'b0;
          @(posedge clk); @(negedge clk);
          if (i > 0) chk("busy_gap", int'(busy[d]), 1);
        end
      end
      in_valid[d]  = 1'b1;
      in_data[d]   = 4'(stim[i]);
      mode_desc[d] = (i == 0) ? desc : !desc;
      guard = 0;
      while (!in_ready[d] && guard < 20) begin
        @(posedge clk); @(negedge clk);
        guard++;
      end
      if (!in_ready[d]) begin
        chk("in_ready_timeout", 0, 1);
        in_valid[d] = 1'b0;
        return;
      end
      @(posedge clk); @(negedge clk);
      chk("busy_load", int'(busy[d]), 1);
    end
    in_valid[d]  = 1'b0;
    mode_desc[d] = 1'b0;
    chk("in_ready_sort", int'(in_ready[d]), 0);
    lat = 0;
    while (!out_valid[d] && lat < 3 * n) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (!out_valid[d]) chk("busy_sort", int'(busy[d]), 1);
    end
    chk("latency", lat, exp_phases + 1);
    if (!out_valid[d]) return;
    for (int k = 0; k < n; k++) begin
      held = out_data[d];
      if (k == stall_word) stalls = 3;
      else stalls = ($urandom_range(99) < stall_pct) ? int'($urandom_range(2, 1)) : 0;
      repeat (stalls) begin
        out_ready[d] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("stall_data", int'(out_data[d]), int'(held));
        chk("stall_valid", int'(out_valid[d]), 1);
      end
      chk("out_valid", int'(out_valid[d]), 1);
      chk("out_data", int'(out_data[d]), exp_q[k]);
      chk("out_last", int'(out_last[d]), (k == n - 1) ? 1 : 0);
      chk("in_ready_drain", int'(in_ready[d]), 0);
      out_ready[d] = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready[d] = 1'b0;
    end
    chk("end_valid", int'(out_valid[d]), 0);
    chk("end_last", int'(out_last[d]), 0);
    chk("end_busy", int'(busy[d]), 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; mode_desc[d] = 1'b0; out_ready[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", int'(in_ready[d]), 0);
      chk("rst_out_valid", int'(out_valid[d]), 0);
      chk("rst_out_data", int'(out_data[d]), 0);
      chk("rst_out_last", int'(out_last[d]), 0);
      chk("rst_busy", int'(busy[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    stim = '{3, 2, 1, 0};   run_batch(0, 1'b0, 0, 0, -1);
    stim = '{0, 1, 2, 3};   run_batch(0, 1'b0, 0, 0, -1);
    stim = '{1, 3, 0, 2};   run_batch(0, 1'b1, 0, 0, -1);
    stim = '{2, 1, 2, 1};   run_batch(0, 1'b0, 60, 0, 1);
    stim = '{15, 0, 7, 7, 8, 1, 14, 2}; run_batch(1, 1'b0, 0, 0, -1);

    // Abort a batch in the middle of SORT phase 1.
    stim = '{3, 2, 1, 0};
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1; in_data[0] = 4'(stim[i]);
      @(posedge clk); @(negedge clk);
    end
    in_valid[0] = 1'b0;
    @(posedge clk); #2;
    chk("pre_abort_busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_out_valid", int'(out_valid[0]), 0);
    chk("abort_in_ready", int'(in_ready[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_batch(0, 1'b0, 0, 0, -1);

    for (int t = 0; t < 30; t++) begin
      int d;
      int n;
      bit narrow;
      d = t % 2;
      n = d ? 8 : 4;
      narrow = ($urandom_range(1) == 1);
      stim = {};
      for (int i = 0; i < n; i++)
        stim.push_back(narrow ? int'($urandom_range(3)) : int'($urandom_range(15)));
      run_batch(d, $urandom_range(1) == 1, 25, 25, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1, "timeout");
  end

endmodule
